// File: rtl/alu_arbiter_2req.sv
// alu_arbiter_2req: round-robin sharing of one registered ALU between two valid/ready requesters.
// Optional grant statistics are enabled by defining ALU_ARB_STATS_EN.
`default_nettype none

module alu_arbiter_2req #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_sel,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_wait_init = 4'(ALU_LAT - 1);

    state_t     r_state;
    logic       r_rr_ptr;
    logic       r_gnt;
    logic [3:0] r_wait;

    logic w_idle;
    logic w_pick1;
    logic w_accept;

    // Requester 1 wins when it is alone, or when both ask and it holds priority.
    assign w_idle     = (r_state == S_IDLE);
    assign w_pick1    = req1_valid & (~req0_valid | r_rr_ptr);
    assign w_accept   = w_idle & (req0_valid | req1_valid);
    assign req0_ready = w_idle & req0_valid & ~w_pick1;
    assign req1_ready = w_idle & w_pick1;
    assign busy       = ~w_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= 1'b0;
            r_gnt      <= 1'b0;
            r_wait     <= 4'd0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 2'b00;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a    <= w_pick1 ? req1_a   : req0_a;
                        alu_b    <= w_pick1 ? req1_b   : req0_b;
                        alu_sel  <= w_pick1 ? req1_sel : req0_sel;
                        r_gnt    <= w_pick1;
                        r_rr_ptr <= ~w_pick1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wait  <= c_wait_init;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait == 4'd0) begin
                        if (r_gnt) begin
                            rsp1_data  <= alu_out;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_data  <= alu_out;
                            rsp0_valid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_RESP: begin
                    if (r_gnt ? rsp1_ready : rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (w_accept) begin
            if (!w_pick1 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (w_pick1 && grant_cnt1 != 16'hFFFF)  grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`else
    assign grant_cnt0 = 16'd0;
    assign grant_cnt1 = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter_2req.sv
// Testbench for alu_arbiter_2req: directed plus randomized ops against a transaction-level model.
`default_nettype none

module tb_alu_arbiter_2req;

    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [1:0]  req0_sel, req1_sel, alu_sel;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        busy;
    logic [15:0] grant_cnt0, grant_cnt1;

    logic        d4_req0_valid, d4_req0_ready, d4_rsp0_valid, d4_rsp0_ready;
    logic        d4_req1_ready, d4_rsp1_valid;
    logic [31:0] d4_req0_a, d4_req0_b, d4_rsp0_data, d4_rsp1_data;
    logic [31:0] d4_alu_a, d4_alu_b;
    logic [1:0]  d4_req0_sel, d4_alu_sel;
    logic        d4_busy;
    logic [15:0] d4_cnt0, d4_cnt1;
    logic [31:0] p4 [4];

    int checks = 0;
    int errors = 0;
    int prio   = 0;
    int gc0    = 0;
    int gc1    = 0;
    int last_g = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);
    always @(posedge clk) begin
        p4[0] <= alu_f(d4_alu_a, d4_alu_b, d4_alu_sel);
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end

    alu_arbiter_2req #(.WIDTH(32), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    alu_arbiter_2req #(.WIDTH(32), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d4_req0_valid), .req0_ready(d4_req0_ready), .req0_a(d4_req0_a),
        .req0_b(d4_req0_b), .req0_sel(d4_req0_sel), .rsp0_valid(d4_rsp0_valid),
        .rsp0_ready(d4_rsp0_ready), .rsp0_data(d4_rsp0_data),
        .req1_valid(1'b0), .req1_ready(d4_req1_ready), .req1_a(32'h0), .req1_b(32'h0),
        .req1_sel(2'b00), .rsp1_valid(d4_rsp1_valid), .rsp1_ready(1'b0), .rsp1_data(d4_rsp1_data),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel), .alu_out(p4[3]),
        .busy(d4_busy), .grant_cnt0(d4_cnt0), .grant_cnt1(d4_cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payload(input int r);
        if (r == 0) begin
            req0_a = $urandom; req0_b = $urandom; req0_sel = 2'($urandom_range(0, 3));
        end else begin
            req1_a = $urandom; req1_b = $urandom; req1_sel = 2'($urandom_range(0, 3));
        end
    endtask

    // One complete transaction from arbitration to response hand-off; hold = back-pressure cycles.
    task automatic serve(input int hold);
        int exp_g, edges, viol, wcnt;
        logic [31:0] exp_d, held;
        #1;
        wcnt = 0;
        while (!(req0_ready || req1_ready) && wcnt < 20) begin
            tick(); #1; wcnt++;
        end
        chk("ready_seen", 64'(req0_ready || req1_ready), 64'd1);
        chk("one_ready", 64'(req0_ready && req1_ready), 64'd0);
        exp_g = (req0_valid && req1_valid) ? prio : (req1_valid ? 1 : 0);
        chk("grant_id", 64'(req1_ready), 64'(exp_g));
        exp_d = (exp_g == 1) ? alu_f(req1_a, req1_b, req1_sel) : alu_f(req0_a, req0_b, req0_sel);
        tick();
        prio   = 1 - exp_g;
        last_g = exp_g;
        if (exp_g == 1) begin gc1++; req1_valid = 1'b0; rand_payload(1); end
        else begin gc0++; req0_valid = 1'b0; rand_payload(0); end
        #1;
        edges = 1;
        viol  = 0;
        while (!((exp_g == 1) ? rsp1_valid : rsp0_valid) && edges < 40) begin
            if (req0_ready || req1_ready || !busy || ((exp_g == 1) ? rsp0_valid : rsp1_valid)) viol++;
            tick(); #1; edges++;
        end
        chk("rsp_latency", 64'(edges), 64'(LAT + 2));
        chk("rsp_data", 64'((exp_g == 1) ? rsp1_data : rsp0_data), 64'(exp_d));
        chk("other_rsp_idle", 64'((exp_g == 1) ? rsp0_valid : rsp1_valid), 64'd0);
        held = (exp_g == 1) ? rsp1_data : rsp0_data;
        for (int i = 0; i < hold; i++) begin
            tick(); #1;
            if (!((exp_g == 1) ? rsp1_valid : rsp0_valid) || req0_ready || req1_ready || !busy ||
                (((exp_g == 1) ? rsp1_data : rsp0_data) !== held)) viol++;
        end
        chk("busy_phase", 64'(viol), 64'd0);
        if (exp_g == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        chk("idle_after_rsp", 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
    endtask

    task automatic chk_stats();
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", 64'(grant_cnt0), 64'(gc0 > 65535 ? 65535 : gc0));
        chk("grant_cnt1", 64'(grant_cnt1), 64'(gc1 > 65535 ? 65535 : gc1));
`else
        chk("grant_cnt0", 64'(grant_cnt0), 64'd0);
        chk("grant_cnt1", 64'(grant_cnt1), 64'd0);
`endif
    endtask

    initial begin
        int viol, edges, r;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_sel = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
        d4_req0_valid = 0; d4_rsp0_ready = 0; d4_req0_a = 0; d4_req0_b = 0; d4_req0_sel = 0;
        #3;
        chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
        chk("rst_rsp", 64'({busy, rsp0_valid, rsp1_valid}), 64'd0);
        chk("rst_alu", {alu_a, alu_b} | 64'(alu_sel), 64'd0);
        chk("rst_data", {rsp0_data, rsp1_data}, 64'd0);
        chk_stats();
        tick();
        rst_n = 1'b1;
        tick();

        // Single op: 1 + 1.
        req0_valid = 1; req0_a = 32'h1; req0_b = 32'h1; req0_sel = 2'b00;
        serve(0);

        // Contention with distinct operands; served requester re-arms.
        req0_valid = 1; req0_a = 5;  req0_b = 3;  req0_sel = 0;
        req1_valid = 1; req1_a = 10; req1_b = 20; req1_sel = 0;
        for (int i = 0; i < 4; i++) begin
            serve(0);
            if (last_g == 1) req1_valid = 1; else req0_valid = 1;
        end

        // Back-pressure on a held response with the other requester pending.
        serve(10);
        serve(0);

        // Randomized mix of requesters, operations and back-pressure.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(1, 3);
            if (!req0_valid && r[0]) begin req0_valid = 1; rand_payload(0); end
            if (!req1_valid && r[1]) begin req1_valid = 1; rand_payload(1); end
            serve($urandom_range(0, 3));
        end
        if (req0_valid || req1_valid) serve(0);
        chk_stats();

        // Reset while waiting on the ALU aborts the op.
        req0_valid = 1; req0_a = 32'h77; req0_b = 32'h11; req0_sel = 2'b01;
        #1;
        chk("pre_abort_ready", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_state", 64'({busy, rsp0_valid, rsp1_valid, req0_ready}), 64'd0);
        chk("abort_alu", {alu_a, alu_b} | 64'(alu_sel), 64'd0);
        chk("abort_data", {rsp0_data, rsp1_data}, 64'd0);
        gc0 = 0; gc1 = 0; prio = 0;
        chk_stats();
        tick();
        rst_n = 1'b1;
        viol = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp0_valid || rsp1_valid || busy) viol++;
        end
        chk("no_rsp_after_abort", 64'(viol), 64'd0);

        // Five grants to requester 0 and three to requester 1.
        req0_valid = 1; rand_payload(0);
        req1_valid = 1; rand_payload(1);
        for (int i = 0; i < 6; i++) begin
            serve(0);
            if (i < 4) begin
                if (last_g == 1) req1_valid = 1; else req0_valid = 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            req0_valid = 1; rand_payload(0);
            serve(1);
        end
        chk_stats();

        // Latency-4 instance: wrap-around add.
        d4_req0_valid = 1; d4_req0_a = 32'hFFFF_FFFF; d4_req0_b = 32'h1; d4_req0_sel = 2'b00;
        #1;
        chk("lat4_ready", 64'(d4_req0_ready), 64'd1);
        tick();
        d4_req0_valid = 0;
        edges = 1;
        while (!d4_rsp0_valid && edges < 40) begin
            tick(); edges++;
        end
        chk("lat4_latency", 64'(edges), 64'd6);
        chk("lat4_data", 64'(d4_rsp0_data), 64'd0);
        d4_rsp0_ready = 1;
        tick();
        d4_rsp0_ready = 0;
        chk("lat4_idle", 64'({d4_busy, d4_rsp0_valid, d4_rsp1_valid}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter_2req.md
Name: alu_arbiter_2req

Overview:
Shares one registered 32-bit ALU (alu32-style: clk, a, b, 2-bit sel, 32-bit out) between two requesters. Each requester has its own valid/ready request channel and valid/ready response channel. A round-robin arbiter grants one operation at a time. An FSM issues the operands, waits out the ALU latency, captures the result and returns it to the granted requester. The block sits between the ALU and the datapath clients in the ALU subsystem.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- ALU_LAT, 1, clock cycles from ALU input sampling to valid alu_out; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 operation valid.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_sel  in  2  requester 0 ALU op select.
- rsp0_valid  out  1  result for requester 0 valid.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_data  out  WIDTH  result for requester 0.
- req1_*/rsp1_*  same set as above, for requester 1.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_sel  out  2  op select to the ALU.
- alu_out  in  WIDTH  ALU result.
- busy  out  1  high whenever the FSM is not in IDLE.
- grant_cnt0, grant_cnt1  out  16  grant statistics (see Optional Feature).

Behaviour:
- Reset (async assert, sync-safe deassert): FSM=IDLE; rr_ptr=0 (requester 0 has priority first); all ready/valid outputs 0; alu_a, alu_b, rsp*_data = 0; alu_sel = 2'b00; busy = 0; wait counter = 0; grant counters = 0.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration (combinational):
  - If only one reqN_valid is high, reqN_ready=1 for that requester.
  - If both are high, the requester selected by rr_ptr gets ready.
  - Never more than one req*_ready high at a time.
  - req*_ready is high only in IDLE.
- Accept = reqN_valid & reqN_ready at a clock edge. At that edge:
  - latch a/b/sel into alu_a/alu_b/alu_sel;
  - record grant id g;
  - set rr_ptr = ~g;
  - go to ISSUE.
- ISSUE lasts 1 cycle; the ALU samples alu_* at the end of it. Then go to WAIT with counter = ALU_LAT-1.
- WAIT: decrement the counter each cycle. When it reaches 0, capture alu_out into rspG_data and go to RESP.
- RESP:
  - rspG_valid = 1; the other rsp*_valid stays 0.
  - rspG_data is held stable while valid and not ready.
  - On rspG_ready, go to IDLE (no same-cycle re-accept).
- Latency: accept edge -> rsp_valid high after ALU_LAT+2 edges (3 edges for ALU_LAT=1). Throughput is one op per ALU_LAT+3 cycles at best.
- alu_a/alu_b/alu_sel hold their last values outside ISSUE/WAIT; no operand glitching.
- Requests arriving while busy are stalled; the requester must hold valid and payload stable until ready.
- A requester whose valid drops before grant is simply not served; nothing is latched.
- rr_ptr changes only on accept, so a lone requester may be granted back-to-back.
- Asserting rst_n mid-operation aborts the op: no response is produced, and all state returns to reset values.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined: grant_cnt0/grant_cnt1 increment on each accept for requester 0/1. They are 16-bit, saturate at 16'hFFFF and clear on reset.
- Undefined: no counter logic; grant_cnt0/grant_cnt1 are tied to 0. Ports exist in both builds.

Test Plan:
- Single op: bench ALU stub returns a+b registered, ALU_LAT=1. req0 a=32'h1, b=32'h1, sel=00 -> req0_ready same cycle, rsp0_valid 3 edges after accept, rsp0_data=32'h2, rsp1_valid stays 0.
- Contention: both valid every cycle from reset, distinct operands -> grants alternate 0,1,0,1, and each rsp carries its own requester's result (e.g. 5+3=8 to req0, 10+20=30 to req1).
- Back-pressure: hold rsp0_ready=0 for 10 cycles -> rsp0_valid and rsp0_data stay stable, req1_ready stays 0, busy=1; release -> IDLE next cycle, then req1 is granted.
- ALU_LAT=4 build: op a=32'hFFFF_FFFF, b=1 -> rsp valid 6 edges after accept, data=32'h0 (wrap).
- Reset mid-WAIT: drop rst_n during WAIT -> all outputs reset immediately, and no rsp_valid appears after release.
- ALU_ARB_STATS_EN defined: 5 grants to req0 and 3 to req1 -> grant_cnt0=5, grant_cnt1=3. Undefined build: both counters read 0.
